// File: rtl/fetch_queue.sv
// Fetch queue: issues sequential instruction-memory reads and buffers {pc, inst} pairs for decode.
// Latency: a request in cycle N is written at the end of N+1, so it is visible to decode in N+2. There is no bypass.
// Backpressure: requests stop once queued plus in-flight entries reach DEPTH. A redirect flushes the queue and drops the response arriving that cycle.
//
// Ports:
//   clk, rst              clock; synchronous active-low reset
//   EX_taken, EX_alt_pc   redirect request and target from execute
//   IM_req, IM_addr       instruction-memory read request and address
//   IM_inst               read data, returned the cycle after IM_req
//   D_valid, D_ready      head-entry handshake toward decode
//   D_pc, D_inst          head entry contents
//   FQ_count              occupied entries
module fetch_queue #(
  parameter int XLEN     = 32,
  parameter int PC_BITS  = 5,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     EX_taken,
  input  logic [PC_BITS-1:0]       EX_alt_pc,
  output logic                     IM_req,
  output logic [PC_BITS-1:0]       IM_addr,
  input  logic [XLEN-1:0]          IM_inst,
  output logic                     D_valid,
  input  logic                     D_ready,
  output logic [PC_BITS-1:0]       D_pc,
  output logic [XLEN-1:0]          D_inst,
  output logic [$clog2(DEPTH):0]   FQ_count
);

  localparam int PW = $clog2(DEPTH);

  logic [PC_BITS-1:0] fetch_pc;
  logic               req_q;
  logic [PC_BITS-1:0] req_pc_q;
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [PW:0]        count;

  logic [PC_BITS-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0]    inst_mem [DEPTH];

  logic [PW+1:0]      occupancy;
  logic               push;
  logic               pop;

  // The in-flight request is counted as occupied so its response always has a slot.
  assign occupancy = {1'b0, count} + {{(PW+1){1'b0}}, req_q};

  assign IM_req   = rst & ~EX_taken & (occupancy < (PW+2)'(DEPTH));
  assign IM_addr  = fetch_pc;

  // Outputs are forced idle during reset so decode never sees stale state.
  assign D_valid  = rst & (count != '0);
  assign D_pc     = pc_mem[rd_ptr];
  assign D_inst   = inst_mem[rd_ptr];
  assign FQ_count = rst ? count : '0;

  // A redirect discards both the arriving response and any pop in the same cycle.
  assign push = rst & req_q & ~EX_taken;
  assign pop  = D_valid & D_ready & ~EX_taken;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= PC_BITS'(RESET_PC);
      req_q    <= 1'b0;
      req_pc_q <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (EX_taken) begin
      fetch_pc <= EX_alt_pc;
      req_q    <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      req_q <= IM_req;
      if (IM_req) begin
        fetch_pc <= fetch_pc + PC_BITS'(1);
        req_pc_q <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc_q;
      inst_mem[wr_ptr] <= IM_inst;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_taken;
  logic [4:0]  EX_alt_pc;
  logic        IM_req;
  logic [4:0]  IM_addr;
  logic [31:0] IM_inst;
  logic        D_valid;
  logic        D_ready;
  logic [4:0]  D_pc;
  logic [31:0] D_inst;
  logic [2:0]  FQ_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(32), .PC_BITS(5), .DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .EX_taken(EX_taken), .EX_alt_pc(EX_alt_pc),
    .IM_req(IM_req), .IM_addr(IM_addr), .IM_inst(IM_inst),
    .D_valid(D_valid), .D_ready(D_ready), .D_pc(D_pc), .D_inst(D_inst),
    .FQ_count(FQ_count)
  );

  // Instruction memory: data = 0x100 + address, returned one cycle after the request.
  logic [4:0] mem_addr_q = '0;
  always @(posedge clk) if (IM_req) mem_addr_q <= IM_addr;
  assign IM_inst = 32'h100 + {27'd0, mem_addr_q};

  // Advance one cycle; inputs are changed 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Outputs are sampled 1 time unit after any input change, well before the next edge.
  task automatic settle();
    #1;
  endtask

  // Leaves the bench in the first cycle with rst=1 (cycle N).
  task automatic do_reset(input logic ready);
    rst = 1'b0; EX_taken = 1'b0; EX_alt_pc = '0; D_ready = ready;
    cyc();
    rst = 1'b1;
    settle();
  endtask

  task automatic test_reset();
    rst = 1'b0; EX_taken = 1'b0; EX_alt_pc = '0; D_ready = 1'b1;
    cyc(); cyc();
    settle();
    checks++; if (IM_req !== 1'b0) begin errors++; $display("FAIL reset_im_req: got %b want 0", IM_req); end
    checks++; if (D_valid !== 1'b0) begin errors++; $display("FAIL reset_d_valid: got %b want 0", D_valid); end
    checks++; if (FQ_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", FQ_count); end
    rst = 1'b1;
    settle();
    checks++; if (IM_req !== 1'b1 || IM_addr !== 5'd0) begin errors++; $display("FAIL reset_first_req: got req=%b addr=%h want req=1 addr=00", IM_req, IM_addr); end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    cyc(); settle();  // N+1: response in flight, nothing queued yet
    checks++; if (D_valid !== 1'b0 || FQ_count !== 3'd0) begin errors++; $display("FAIL b2b_n1: got valid=%b count=%0d want valid=0 count=0", D_valid, FQ_count); end
    for (int k = 0; k < 6; k++) begin
      cyc(); settle();
      checks++;
      if (D_valid !== 1'b1 || D_pc !== 5'(k) || D_inst !== 32'h100 + 32'(k)) begin
        errors++;
        $display("FAIL b2b_deliver%0d: got valid=%b pc=%h inst=%h want valid=1 pc=%h inst=%h", k, D_valid, D_pc, D_inst, 5'(k), 32'h100 + 32'(k));
      end
    end
    checks++; if (FQ_count !== 3'd1) begin errors++; $display("FAIL b2b_steady_count: got %0d want 1", FQ_count); end
  endtask

  task automatic test_full();
    do_reset(1'b0);
    cyc(); cyc(); cyc(); cyc(); settle();  // N+4
    checks++; if (IM_req !== 1'b0 || FQ_count !== 3'd3) begin errors++; $display("FAIL full_n4: got req=%b count=%0d want req=0 count=3", IM_req, FQ_count); end
    cyc(); settle();  // N+5
    checks++; if (FQ_count !== 3'd4 || IM_req !== 1'b0) begin errors++; $display("FAIL full_sat: got count=%0d req=%b want count=4 req=0", FQ_count, IM_req); end
    cyc(); settle();  // N+6
    checks++; if (FQ_count !== 3'd4 || D_pc !== 5'd0) begin errors++; $display("FAIL full_hold: got count=%0d pc=%h want count=4 pc=00", FQ_count, D_pc); end
    D_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++;
      if (D_valid !== 1'b1 || D_pc !== 5'(i)) begin
        errors++;
        $display("FAIL full_drain%0d: got valid=%b pc=%h want valid=1 pc=%h", i, D_valid, D_pc, 5'(i));
      end
      if (i == 1) begin
        checks++;
        if (IM_req !== 1'b1 || IM_addr !== 5'd4) begin errors++; $display("FAIL full_resume: got req=%b addr=%h want req=1 addr=04", IM_req, IM_addr); end
      end
      cyc();
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    cyc(); cyc(); cyc(); cyc();  // N+4: count=3, request for pc 3 outstanding
    EX_taken = 1'b1; EX_alt_pc = 5'h10; D_ready = 1'b1;
    settle();
    checks++; if (IM_req !== 1'b0) begin errors++; $display("FAIL redir_req_same: got %b want 0", IM_req); end
    cyc();
    EX_taken = 1'b0;
    settle();
    checks++; if (FQ_count !== 3'd0 || D_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got count=%0d valid=%b want count=0 valid=0", FQ_count, D_valid); end
    checks++; if (IM_req !== 1'b1 || IM_addr !== 5'h10) begin errors++; $display("FAIL redir_target: got req=%b addr=%h want req=1 addr=10", IM_req, IM_addr); end
    cyc(); settle();
    checks++; if (FQ_count !== 3'd0) begin errors++; $display("FAIL redir_stale: got count=%0d want 0", FQ_count); end
    cyc(); settle();
    checks++; if (D_valid !== 1'b1 || D_pc !== 5'h10 || D_inst !== 32'h110) begin errors++; $display("FAIL redir_deliver: got valid=%b pc=%h inst=%h want valid=1 pc=10 inst=00000110", D_valid, D_pc, D_inst); end
    cyc(); settle();
    checks++; if (D_pc !== 5'h11) begin errors++; $display("FAIL redir_next: got pc=%h want 11", D_pc); end
  endtask

  task automatic test_wrap();
    logic [4:0] exp_pc [4];
    exp_pc[0] = 5'h1E; exp_pc[1] = 5'h1F; exp_pc[2] = 5'h00; exp_pc[3] = 5'h01;
    do_reset(1'b1);
    EX_taken = 1'b1; EX_alt_pc = 5'h1E;
    cyc();
    EX_taken = 1'b0;
    cyc(); cyc(); settle();  // N+3
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (D_valid !== 1'b1 || D_pc !== exp_pc[i]) begin
        errors++;
        $display("FAIL wrap%0d: got valid=%b pc=%h want valid=1 pc=%h", i, D_valid, D_pc, exp_pc[i]);
      end
      cyc(); settle();
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    cyc(); cyc(); cyc(); settle();  // N+3
    checks++; if (FQ_count !== 3'd2) begin errors++; $display("FAIL rmid_pre: got count=%0d want 2", FQ_count); end
    rst = 1'b0;
    settle();
    checks++; if (IM_req !== 1'b0 || D_valid !== 1'b0) begin errors++; $display("FAIL rmid_during: got req=%b valid=%b want req=0 valid=0", IM_req, D_valid); end
    cyc();
    rst = 1'b1;
    settle();
    checks++; if (FQ_count !== 3'd0 || D_valid !== 1'b0) begin errors++; $display("FAIL rmid_clear: got count=%0d valid=%b want count=0 valid=0", FQ_count, D_valid); end
    checks++; if (IM_req !== 1'b1 || IM_addr !== 5'd0) begin errors++; $display("FAIL rmid_restart: got req=%b addr=%h want req=1 addr=00", IM_req, IM_addr); end
  endtask

  task automatic test_reset_vs_redirect();
    do_reset(1'b1);
    cyc(); cyc();
    rst = 1'b0; EX_taken = 1'b1; EX_alt_pc = 5'h08;
    cyc();
    rst = 1'b1; EX_taken = 1'b0;
    settle();
    checks++; if (IM_req !== 1'b1 || IM_addr !== 5'd0) begin errors++; $display("FAIL rvr_addr: got req=%b addr=%h want req=1 addr=00", IM_req, IM_addr); end
    cyc(); cyc(); settle();
    checks++; if (D_valid !== 1'b1 || D_pc !== 5'd0) begin errors++; $display("FAIL rvr_deliver: got valid=%b pc=%h want valid=1 pc=00", D_valid, D_pc); end
  endtask

  initial begin
    rst = 1'b0; EX_taken = 1'b0; EX_alt_pc = '0; D_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_full();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_reset_vs_redirect();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
